iop_dispatch: RTL

//   CPU-side I/O dispatcher, directly upstream of the IOP block.

---
 rtl/iop_pkg.sv | 48 ++++
 rtl/iop_dispatch_if.sv | 46 ++++
 rtl/iop_done_snoop.sv | 28 ++
 rtl/iop_dispatch.sv | 135 +++++++++++++
 4 files changed

// File: rtl/iop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iop_pkg
// Description : Shared constants, dispatch state encoding and decode helpers
//               for the CPU-side I/O dispatcher (iop_dispatch) and its
//               completion snooper.
// Revision    : 1.0 - initial release
// ============================================================================
package iop_pkg;

    // CPU I/O function codes carried on req_func
    localparam logic [0:2] FNC_SIO = 3'd0;
    localparam logic [0:2] FNC_TIO = 3'd1;
    localparam logic [0:2] FNC_TDV = 3'd2;
    localparam logic [0:2] FNC_HIO = 3'd3;
    localparam logic [0:2] FNC_AIO = 3'd6;

    // Condition codes returned with ack
    localparam logic [0:1] CC_OK    = 2'b00;
    localparam logic [0:1] CC_NOTOP = 2'b11;

    // Completion word the IOP writes when an SIO finishes
    localparam logic [15:31] DONE_WORD_ADDR = 17'h00021;
    localparam logic [0:7]   DONE_OPCODE    = 8'h0E;

    // Devices that actually exist behind the IOP (device field 24:31)
    localparam logic [0:7] KNOWN_DEV_A = 8'd1;
    localparam logic [0:7] KNOWN_DEV_B = 8'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RESP    = 3'd4
    } dispatch_state_e;

    function automatic logic is_known_dev(input logic [0:7] dev);
        return (dev == KNOWN_DEV_A) || (dev == KNOWN_DEV_B);
    endfunction

    function automatic logic is_supported_func(input logic [0:2] fnc);
        return (fnc == FNC_SIO) || (fnc == FNC_TIO) || (fnc == FNC_TDV) ||
               (fnc == FNC_HIO) || (fnc == FNC_AIO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iop_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : iop_dispatch_if
// Description : Bundles the CPU request/acknowledge handshake, the IOP
//               control outputs and the snooped memory write bus.
//               slave  : the dispatcher (drives busy/ack/iop_*)
//               master : the CPU / IOP / memory side (drives req/mem_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface iop_dispatch_if;

    // CPU request / response
    logic          req;
    logic [0:2]    req_func;
    logic [21:31]  req_device;
    logic          busy;
    logic          ack;
    logic [0:1]    ack_cc;
    logic          ack_timeout;

    // IOP control
    logic          iop_active;
    logic [0:2]    iop_func;
    logic [21:31]  iop_device;

    // Snooped memory write path
    logic [15:31]  mem_address;
    logic [0:31]   mem_data;
    logic [0:3]    mem_wr_enables;

    modport slave (
        input  req, req_func, req_device,
        input  mem_address, mem_data, mem_wr_enables,
        output busy, ack, ack_cc, ack_timeout,
        output iop_active, iop_func, iop_device
    );

    modport master (
        output req, req_func, req_device,
        output mem_address, mem_data, mem_wr_enables,
        input  busy, ack, ack_cc, ack_timeout,
        input  iop_active, iop_func, iop_device
    );

endinterface
`default_nettype wire

// File: rtl/iop_done_snoop.sv
`default_nettype none
// ============================================================================
// Module      : iop_done_snoop
// Description : Combinational detector for the IOP completion write: a full
//               word write to DONE_WORD_ADDR whose leading byte is
//               DONE_OPCODE.
// Ports       : mem_address_i    - snooped word address [15:31]
//               mem_opcode_i     - snooped write data byte [0:7]
//               mem_wr_enables_i - snooped byte enables [0:3]
//               done_o           - completion word present this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module iop_done_snoop
    import iop_pkg::*;
(
    input  logic [15:31] mem_address_i,
    input  logic [0:7]   mem_opcode_i,
    input  logic [0:3]   mem_wr_enables_i,
    output logic         done_o
);

    // Partial writes never count, even to the right word with the right opcode
    assign done_o = (mem_wr_enables_i == 4'hF)
                 && (mem_address_i == DONE_WORD_ADDR)
                 && (mem_opcode_i == DONE_OPCODE);

endmodule
`default_nettype wire

// File: rtl/iop_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : iop_dispatch
// Description : CPU-side I/O dispatcher in front of the IOP. Takes one
//               request at a time; SIO to a known device drives the IOP
//               until its completion word is snooped or a timeout expires,
//               every other request is answered locally.
// Ports       : clock - system clock, rising edge
//               reset - synchronous, active-high
//               bus   - iop_dispatch_if.slave (CPU handshake, IOP control,
//                       snooped memory write bus)
// Parameters  : TIMEOUT_CYCLES - max cycles iop_active stays high per SIO
// Revision    : 1.0 - initial release
// ============================================================================
module iop_dispatch
    import iop_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          clock,
    input  logic          reset,
    iop_dispatch_if.slave bus
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]   TIMER_MAX  = '1;

    dispatch_state_e state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [0:2]      func_q, func_d;
    logic [21:31]    dev_q, dev_d;
    // Outcome decided in DECODE/RUN, published on ack in RESP
    logic [0:1]      res_cc_q, res_cc_d;
    logic            res_to_q, res_to_d;
    logic            ack_q;
    logic [0:1]      ack_cc_q;
    logic            ack_to_q;
    logic            active_q;
    logic            snoop_done;

    iop_done_snoop u_snoop (
        .mem_address_i    (bus.mem_address),
        .mem_opcode_i     (bus.mem_data[0:7]),
        .mem_wr_enables_i (bus.mem_wr_enables),
        .done_o           (snoop_done)
    );

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        func_d   = func_q;
        dev_d    = dev_q;
        res_cc_d = res_cc_q;
        res_to_d = res_to_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    func_d  = bus.req_func;
                    dev_d   = bus.req_device;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                res_to_d = 1'b0;
                if (!is_supported_func(func_q) || !is_known_dev(dev_q[24:31])) begin
                    res_cc_d = CC_NOTOP;
                    state_d  = ST_RESP;
                end else if (func_q == FNC_SIO) begin
                    timer_d = '0;
                    state_d = ST_RUN;
                end else begin
                    res_cc_d = CC_OK;
                    state_d  = ST_RESP;
                end
            end
            ST_RUN: begin
                timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
                // Completion takes priority over a timeout in the same cycle
                if (snoop_done) begin
                    res_cc_d = CC_OK;
                    res_to_d = 1'b0;
                    state_d  = ST_RELEASE;
                end else if (timer_q == TIMER_LAST) begin
                    res_cc_d = CC_NOTOP;
                    res_to_d = 1'b1;
                    state_d  = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            func_q   <= '0;
            dev_q    <= '0;
            res_cc_q <= '0;
            res_to_q <= 1'b0;
            ack_q    <= 1'b0;
            ack_cc_q <= '0;
            ack_to_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            func_q   <= func_d;
            dev_q    <= dev_d;
            res_cc_q <= res_cc_d;
            res_to_q <= res_to_d;
            // Registered from next state so iop_active and ack track the
            // state register exactly, with no decode glitches
            active_q <= (state_d == ST_RUN);
            ack_q    <= (state_d == ST_RESP);
            if (state_d == ST_RESP) begin
                ack_cc_q <= res_cc_d;
                ack_to_q <= res_to_d;
            end
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.ack         = ack_q;
    assign bus.ack_cc      = ack_cc_q;
    assign bus.ack_timeout = ack_to_q;
    assign bus.iop_active  = active_q;
    assign bus.iop_func    = func_q;
    assign bus.iop_device  = dev_q;

endmodule
`default_nettype wire
